// File: rtl/affine_param_loader.sv
// rtl/affine_param_loader.sv - gathers RNG words into a staged T/t pair and commits it atomically
module affine_param_loader #(
    parameter int STATE_W = 16,
    parameter int RND_W   = 32,
    parameter int N_WORDS = (STATE_W*STATE_W + STATE_W + RND_W - 1) / RND_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       refresh_req,
    input  logic [RND_W-1:0]           rnd_in,
    input  logic                       rnd_valid,
    output logic                       rnd_ready,
    input  logic                       commit_en,
    output logic [STATE_W*STATE_W-1:0] T_out,
    output logic [STATE_W-1:0]         t_out,
    output logic                       busy,
    output logic                       update
);
    localparam int T_W   = STATE_W*STATE_W;
    localparam int S_W   = T_W + STATE_W;
    localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    function automatic logic [T_W-1:0] identity_matrix();
        logic [T_W-1:0] m;
        m = '0;
        for (int i = 0; i < STATE_W; i++) begin
            m[i*STATE_W + i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [T_W-1:0] T_IDENT = identity_matrix();

    typedef enum logic [1:0] {IDLE, FILL, WAIT_COMMIT} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [S_W-1:0]   stage;
    logic             start;
    logic             accept;
    logic             commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rnd_ready  = 1'b0;
        start      = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (refresh_req) begin
                    start      = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                rnd_ready = 1'b1;
                if (rnd_valid) begin
                    accept = 1'b1;
                    if (cnt == LAST_IDX) begin
                        next_state = WAIT_COMMIT;
                    end
                end
            end
            WAIT_COMMIT: begin
                // refresh_req is deliberately not looked at here, so a request
                // coinciding with the commit is dropped rather than queued.
                if (commit_en) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stage  <= '0;
            T_out  <= T_IDENT;
            t_out  <= '0;
            update <= 1'b0;
        end else begin
            update <= commit;
            if (start) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            // Bitwise write keeps every index in range; bits of the last word
            // beyond the staging width simply have no destination.
            for (int p = 0; p < S_W; p++) begin
                if (accept && cnt == CNT_W'(p / RND_W)) begin
                    stage[p] <= rnd_in[p % RND_W];
                end
            end
            if (commit) begin
                T_out <= stage[T_W-1:0];
                t_out <= stage[S_W-1:T_W];
            end
        end
    end
endmodule

// File: tb/tb_affine_param_loader.sv
// tb/tb_affine_param_loader.sv - randomized and directed check of affine_param_loader against a queue model
module tb_affine_param_loader;
    localparam int SW = 16;
    localparam int RW = 32;
    localparam int NW = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           refresh_req = 1'b0;
    logic [RW-1:0]  rnd_in = '0;
    logic           rnd_valid = 1'b0;
    logic           rnd_ready;
    logic           commit_en = 1'b0;
    logic [SW*SW-1:0] T_out;
    logic [SW-1:0]  t_out;
    logic           busy;
    logic           update;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    affine_param_loader dut (
        .clk(clk), .rst_n(rst_n), .refresh_req(refresh_req),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .commit_en(commit_en), .T_out(T_out), .t_out(t_out),
        .busy(busy), .update(update)
    );

    task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [SW*SW-1:0] ident();
        logic [SW*SW-1:0] m;
        m = '0;
        for (int i = 0; i < SW; i++) m[i*SW +: SW] = 16'h0001 << i;
        return m;
    endfunction

    logic [RW-1:0] words[NW];

    function automatic logic [271:0] pack_words();
        logic [NW*RW-1:0] big;
        for (int k = 0; k < NW; k++) big[k*RW +: RW] = words[k];
        return big[271:0];
    endfunction

    // Transaction-level model: a word queue plus the committed pair.
    logic [RW-1:0]    m_q[$];
    logic [NW*RW-1:0] m_big;
    bit               m_fill, m_wait, m_upd, model_on;
    logic [SW*SW-1:0] m_T;
    logic [SW-1:0]    m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_fill = 0; m_wait = 0; m_upd = 0;
            m_T = ident(); m_t = '0;
        end else begin
            m_upd = 0;
            if (m_wait) begin
                if (commit_en) begin
                    for (int k = 0; k < NW; k++) m_big[k*RW +: RW] = m_q[k];
                    m_T = m_big[255:0];
                    m_t = m_big[271:256];
                    m_upd = 1; m_wait = 0;
                end
            end else if (m_fill) begin
                if (rnd_valid) begin
                    m_q.push_back(rnd_in);
                    if (m_q.size() == NW) begin m_fill = 0; m_wait = 1; end
                end
            end else if (refresh_req) begin
                m_fill = 1;
                m_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("T_out", T_out, m_T);
            chk("t_out", t_out, m_t);
            chk("busy", busy, m_fill || m_wait);
            chk("rnd_ready", rnd_ready, m_fill);
            chk("update", update, m_upd);
        end
    end

    int hs_cnt = 0;
    int upd_seen = 0;
    always @(posedge clk) if (rst_n && rnd_valid && rnd_ready) hs_cnt++;
    always @(negedge clk) if (update) upd_seen++;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_refresh(input bit stall, input bit cen, input int req_at, input int n_stop);
        int idx = 0;
        int guard = 0;
        bit acc;
        refresh_req = 1; commit_en = cen;
        tick();
        refresh_req = 0;
        while (idx < n_stop && guard < 200) begin
            rnd_valid   = stall ? (guard % 2 == 1) : 1'b1;
            rnd_in      = words[idx];
            refresh_req = (idx == req_at);
            if (stall) chk("ready_in_fill", rnd_ready, 1'b1);
            acc = rnd_valid && rnd_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        rnd_valid = 0; refresh_req = 0;
        if (idx != n_stop) chk("fill_timeout", idx, n_stop);
    endtask

    logic [SW*SW-1:0] lit_T;
    logic [SW*SW-1:0] exp_T;
    logic [SW-1:0]    exp_t;

    initial begin
        for (int k = 0; k < 8; k++) begin
            lit_T[(2*k)*SW +: SW]   = 16'(k);
            lit_T[(2*k+1)*SW +: SW] = 16'hA5A5;
        end

        tick();
        model_on = 1;
        tick();
        rst_n = 1;
        tick();

        // Full refresh, back-to-back words, commit_en always high
        for (int k = 0; k < NW; k++) words[k] = 32'hA5A5_0000 + k;
        hs_cnt = 0; upd_seen = 0;
        do_refresh(0, 1, -1, NW);
        chk("t2_upd_before", update, 1'b0);
        chk("t2_busy_wait", busy, 1'b1);
        tick();
        chk("t2_upd_pulse", update, 1'b1);
        chk("t2_T", T_out, lit_T);
        chk("t2_t", t_out, 16'h0008);
        tick();
        chk("t2_upd_after", update, 1'b0);
        chk("t2_busy_idle", busy, 1'b0);
        chk("t2_accepts", hs_cnt, 9);
        chk("t2_upd_count", upd_seen, 1);

        // Asynchronous reset mid-cycle, no clock edge
        rst_n = 0;
        #1;
        chk("rst_T", T_out, ident());
        chk("rst_t", t_out, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", rnd_ready, 1'b0);
        chk("rst_update", update, 1'b0);
        tick();
        rst_n = 1;
        tick();

        // Alternate-cycle stalls
        do_refresh(1, 1, -1, NW);
        tick(); tick();
        chk("t3_T", T_out, lit_T);
        chk("t3_t", t_out, 16'h0008);

        // Commit gating
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        {exp_t, exp_T} = pack_words();
        do_refresh(0, 0, -1, NW);
        for (int c = 0; c < 20; c++) begin
            chk("t4_hold_T", T_out, lit_T);
            chk("t4_hold_busy", busy, 1'b1);
            chk("t4_hold_ready", rnd_ready, 1'b0);
            tick();
        end
        commit_en = 1;
        tick();
        chk("t4_upd", update, 1'b1);
        chk("t4_T", T_out, exp_T);
        chk("t4_t", t_out, exp_t);
        tick();
        chk("t4_upd_after", update, 1'b0);

        // Requests while busy, including one coinciding with the commit
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        hs_cnt = 0; upd_seen = 0;
        do_refresh(0, 0, 3, NW);
        rnd_valid = 1;
        tick();
        refresh_req = 1;
        tick();
        refresh_req = 0;
        tick();
        refresh_req = 1; commit_en = 1;
        tick();
        refresh_req = 0; commit_en = 0;
        chk("t5_busy_after_commit", busy, 1'b0);
        tick();
        rnd_valid = 0;
        chk("t5_busy_idle", busy, 1'b0);
        chk("t5_accepts", hs_cnt, 9);
        chk("t5_upd_count", upd_seen, 1);

        // Reset mid-fill, then a fresh refresh
        for (int k = 0; k < NW; k++) words[k] = $urandom;
        do_refresh(0, 1, -1, 5);
        rst_n = 0;
        upd_seen = 0;
        tick();
        rst_n = 1;
        tick();
        chk("t6_no_early_upd", upd_seen, 0);
        for (int k = 0; k < NW; k++) words[k] = 32'h1111_1111 * k;
        do_refresh(0, 1, -1, NW);
        tick();
        chk("t6_upd", update, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t6_row_lo", T_out[(2*k)*SW +: SW], 16'(32'h1111_1111 * k));
            chk("t6_row_hi", T_out[(2*k+1)*SW +: SW], 16'((32'h1111_1111 * k) >> 16));
        end
        chk("t6_t", t_out, 16'h8888);
        tick();
        chk("t6_upd_count", upd_seen, 1);

        // Random traffic with level-held requests and occasional resets
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 < 100) refresh_req = ($urandom % 5 == 0);
            else               refresh_req = (c % 200 < 160);
            rnd_valid = ($urandom % 3 != 0);
            rnd_in    = $urandom;
            commit_en = ($urandom % 4 != 0);
            rst_n     = ($urandom % 400 != 0);
            tick();
        end
        rst_n = 1; refresh_req = 0; rnd_valid = 0; commit_en = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
